// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit (master) and the memory (slave).
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, wdata, be, input rdata, ack);
  modport slave  (input req, we, addr, wdata, be, output rdata, ack);
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: aligns and issues one bus transfer per access,
// stalls the pipeline until ack or timeout, then sign/zero-extends the load result.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_mem,
  input  logic              mem_write_mem,
  input  logic [1:0]        mem_size_mem,
  input  logic              mem_unsigned_mem,
  input  logic [31:0]       alu_result_mem,
  input  logic [31:0]       write_data_mem,
  mem_access_unit_if.master dmem,
  output logic [31:0]       read_data_mem,
  output logic              mem_stall,
  output logic              misaligned,
  output logic              bus_error
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state;
  logic        access;
  logic        is_misaligned;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic        timeout_hit;
  logic [4:0]  wait_cnt;
  logic [31:0] rdata_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic        unsigned_q;
  logic        load_q;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;

  assign access = mem_read_mem | mem_write_mem;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    is_misaligned = 1'b0;
    be_next       = 4'b1111;
    wdata_next    = write_data_mem;
    unique case (mem_size_mem)
      2'b00: begin
        be_next    = 4'b0001 << alu_result_mem[1:0];
        wdata_next = {4{write_data_mem[7:0]}};
      end
      2'b01: begin
        is_misaligned = alu_result_mem[0];
        be_next       = alu_result_mem[1] ? 4'b1100 : 4'b0011;
        wdata_next    = {2{write_data_mem[15:0]}};
      end
      default: is_misaligned = |alu_result_mem[1:0];  // 11 behaves as word
    endcase
  end

  // Ack arriving in the last allowed cycle beats the timeout.
  assign timeout_hit = (state == ACCESS) && !dmem.ack && (wait_cnt == 5'(TIMEOUT - 1));

  assign mem_stall  = !reset && ((state == ACCESS) || (state == IDLE && access && !is_misaligned));
  assign misaligned = !reset && (state == IDLE) && access && is_misaligned;
  assign bus_error  = timeout_hit;

  always_comb begin
    lane_byte = rdata_q[{lane_q, 3'b000} +: 8];
    lane_half = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    unique case (size_q)
      2'b00:   load_ext = {{24{~unsigned_q & lane_byte[7]}}, lane_byte};
      2'b01:   load_ext = {{16{~unsigned_q & lane_half[15]}}, lane_half};
      default: load_ext = rdata_q;
    endcase
    read_data_mem = (state == DONE && load_q) ? load_ext : 32'h0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      dmem.req   <= 1'b0;
      dmem.we    <= 1'b0;
      dmem.addr  <= 32'h0;
      dmem.wdata <= 32'h0;
      dmem.be    <= 4'b0000;
      rdata_q    <= 32'h0;
      wait_cnt   <= 5'd0;
      size_q     <= 2'b00;
      lane_q     <= 2'b00;
      unsigned_q <= 1'b0;
      load_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (access && !is_misaligned) begin
            state      <= ACCESS;
            dmem.req   <= 1'b1;
            dmem.we    <= mem_write_mem;
            dmem.addr  <= {alu_result_mem[31:2], 2'b00};
            dmem.wdata <= wdata_next;
            dmem.be    <= be_next;
            wait_cnt   <= 5'd0;
            size_q     <= mem_size_mem;
            lane_q     <= alu_result_mem[1:0];
            unsigned_q <= mem_unsigned_mem;
            load_q     <= !mem_write_mem;  // read+write counts as a store
          end
        end
        ACCESS: begin
          if (dmem.ack || timeout_hit) begin
            state    <= DONE;
            dmem.req <= 1'b0;
            dmem.we  <= 1'b0;
            dmem.be  <= 4'b0000;
            rdata_q  <= dmem.ack ? dmem.rdata : 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 5'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The unit SHALL have these ports, as name, direction, width and meaning:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_read_mem  in  1  load in MEM stage.
- mem_write_mem  in  1  store in MEM stage.
- mem_size_mem  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- mem_unsigned_mem  in  1  zero-extend loads when 1, sign-extend when 0.
- alu_result_mem  in  32  byte address.
- write_data_mem  in  32  store data, right-justified.
- dmem_req  out  1  bus request; registered.
- dmem_we  out  1  bus write enable; registered.
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}); registered.
- dmem_wdata  out  32  lane-replicated store data; registered.
- dmem_be  out  4  byte enables, bit n = byte lane n (little-endian); registered.
- dmem_rdata  in  32  bus read data; valid when dmem_ack=1.
- dmem_ack  in  1  bus completion, single-cycle pulse.
- read_data_mem  out  32  extended load result, feeds the MEM/WB register.
- mem_stall  out  1  freeze PC/IF/ID/EX/MEM registers; combinational.
- misaligned  out  1  single-cycle alignment fault pulse.
- bus_error  out  1  single-cycle timeout fault pulse.

REQ-002 The unit SHALL use one clock, clk, and an asynchronous, active-high reset, reset.

REQ-003 The unit SHALL have one parameter, TIMEOUT, default 16: the maximum number of ACCESS cycles without dmem_ack before the access is abandoned.

Function
REQ-004 The FSM SHALL have three states (IDLE, ACCESS, DONE) and SHALL reset to IDLE.

REQ-005 access = mem_read_mem | mem_write_mem; if both are set, the access SHALL be treated as a store.

REQ-006 Alignment rule:
- half with addr[0]=1 is misaligned.
- word with addr[1:0]!=00 is misaligned.
- byte is never misaligned.

REQ-007 In IDLE with an aligned access:
- mem_stall SHALL be 1.
- On the next edge the unit SHALL go to ACCESS and register dmem_req=1, dmem_we, dmem_addr, dmem_be and dmem_wdata.

REQ-008 In IDLE with a misaligned access:
- misaligned SHALL be 1 for that cycle.
- mem_stall SHALL be 0.
- No request SHALL be issued.
- read_data_mem SHALL be 0.
- The FSM SHALL stay in IDLE.

REQ-009 In ACCESS:
- dmem_req and all bus outputs SHALL hold stable.
- mem_stall SHALL be 1, including in the cycle dmem_ack=1.
- On dmem_ack=1 the unit SHALL capture dmem_rdata, deassert dmem_req on the next edge and go to DONE.

REQ-010 Byte enables:
- byte: one-hot at addr[1:0].
- half: 0011 for addr[1]=0, 1100 for addr[1]=1.
- word: 1111.

REQ-011 dmem_wdata lane replication:
- byte: {4{wd[7:0]}}.
- half: {2{wd[15:0]}}.
- word: wd.

REQ-012 Load extraction SHALL select the addressed lane from the captured data, then zero- or sign-extend to 32 bits per mem_unsigned_mem.

REQ-013 In DONE:
- mem_stall SHALL be 0.
- read_data_mem SHALL present the extracted load value for loads, and 0 for stores.
- The FSM SHALL return to IDLE on the next edge.

REQ-014 Latency: a zero-wait bus (ack in the first ACCESS cycle) SHALL give 2 stall cycles, and each wait cycle SHALL add 1 stall cycle.

REQ-015 Timeout:
- A 5-bit counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle without ack.
- When the counter reaches TIMEOUT-1 without ack, bus_error SHALL pulse for 1 cycle, dmem_req SHALL drop, captured data SHALL be forced to 0, and the FSM SHALL go to DONE.

REQ-016 If ack and timeout occur in the same cycle, ack SHALL win: no bus_error, and the data is captured.

REQ-017 In IDLE with no access, mem_stall SHALL be 0, read_data_mem SHALL be 0, and the bus outputs SHALL be idle (req=0, we=0, be=0000).

REQ-018 Access-control inputs changing during ACCESS or DONE SHALL be ignored; the unit SHALL use only the values registered at IDLE exit.

Reset
REQ-019 reset=1 SHALL immediately force:
- state IDLE.
- dmem_req=0, dmem_we=0, dmem_be=0000, dmem_addr=0, dmem_wdata=0.
- captured data 0, counter 0.
- read_data_mem=0, mem_stall=0, misaligned=0, bus_error=0.

REQ-020 Reset asserted mid-ACCESS SHALL abandon the transfer, and a dmem_ack arriving afterwards while in IDLE SHALL be ignored.

Verification
REQ-021 LW at 0x100, ack in 1st ACCESS cycle, rdata 0xDEADBEEF -> stall 2 cycles, be=1111; DONE read_data_mem=0xDEADBEEF.

REQ-022 LB signed at 0x103, rdata 0x80FFFFFF -> be=1000, read_data_mem=0xFFFFFF80; LBU -> 0x00000080.

REQ-023 SH at 0x202, data 0x0000ABCD, ack after 3 waits -> dmem_addr=0x200, be=1100, wdata=0xABCDABCD, we=1, stall 5 cycles.

REQ-024 LW at 0x101 -> misaligned pulse 1 cycle, no dmem_req, stall 0.

REQ-025 LW with no ack, TIMEOUT=16 -> bus_error at ACCESS cycle 16, read_data_mem=0 in DONE; ack coincident with cycle 16 -> no bus_error.

REQ-026 Reset at 2nd ACCESS cycle, then ack -> dmem_req=0 immediately, state IDLE, no capture.
